// File: rtl/bitblade_slice_sequencer.sv
// Slice sequencer for a 2x2-bit multiplier slice.
// Steps every act/wgt slice pair and shift-accumulates the products.
module bitblade_slice_sequencer #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       act,
    input  logic [7:0]       wgt,
    input  logic [1:0]       prec_i,
    input  logic [1:0]       prec_w,
    input  logic             signed_i,
    input  logic             signed_w,
    input  logic             last,
    output logic [1:0]       mul_a,
    output logic [1:0]       mul_b,
    output logic             mul_sign_i,
    output logic             mul_sign_w,
    input  logic [5:0]       mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [7:0]       act_q;
    logic [7:0]       wgt_q;
    logic [1:0]       ni_q;
    logic [1:0]       nw_q;
    logic             si_q;
    logic             sw_q;
    logic             last_q;
    logic [1:0]       i_q;
    logic [1:0]       j_q;
    logic [ACC_W-1:0] acc_q;

    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] pext;
    logic [4:0]       shamt;
    logic             run;
    logic             last_pair;

    assign run       = (state_q == RUN);
    assign last_pair = (i_q == ni_q) && (j_q == nw_q);

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_acc   = out_valid ? acc_q : '0;

    // Slice selection and sign controls toward the multiplier; idle when not running.
    always_comb begin
        mul_a      = 2'b00;
        mul_b      = 2'b00;
        mul_sign_i = 1'b0;
        mul_sign_w = 1'b0;
        if (run) begin
            mul_a      = act_q[{i_q, 1'b0} +: 2];
            mul_b      = wgt_q[{j_q, 1'b0} +: 2];
            mul_sign_i = si_q & (i_q == ni_q);
            mul_sign_w = sw_q & (j_q == nw_q);
        end
    end

    // Sign-extend the slice product and weight it by 4^(i+j).
    always_comb begin
        shamt = {({1'b0, i_q} + {1'b0, j_q}), 1'b0};
        pext  = {{(ACC_W-6){mul_p[5]}}, mul_p};
        acc_d = acc_q + (pext << shamt);
    end

    // Control FSM: latch item, walk slice pairs (j inner), hold result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            act_q   <= '0;
            wgt_q   <= '0;
            ni_q    <= '0;
            nw_q    <= '0;
            si_q    <= 1'b0;
            sw_q    <= 1'b0;
            last_q  <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        act_q   <= act;
                        wgt_q   <= wgt;
                        ni_q    <= prec_i;
                        nw_q    <= prec_w;
                        si_q    <= signed_i;
                        sw_q    <= signed_w;
                        last_q  <= last;
                        i_q     <= '0;
                        j_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (j_q == nw_q) begin
                        j_q <= '0;
                        if (last_pair) begin
                            i_q     <= '0;
                            state_q <= last_q ? DONE : IDLE;
                        end else begin
                            i_q <= i_q + 2'd1;
                        end
                    end else begin
                        j_q <= j_q + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitblade_slice_sequencer.sv
// Directed bench for bitblade_slice_sequencer.
// Models the external 2x2 multiplier slice and checks results and timing.
module tb_bitblade_slice_sequencer;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    act;
    logic [7:0]    wgt;
    logic [1:0]    prec_i;
    logic [1:0]    prec_w;
    logic          signed_i;
    logic          signed_w;
    logic          last;
    logic [1:0]    mul_a;
    logic [1:0]    mul_b;
    logic          mul_sign_i;
    logic          mul_sign_w;
    logic [5:0]    mul_p;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_acc;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] hsi;
    logic [15:0] hsw;
    logic [1:0]  ha0;
    logic [1:0]  hb0;

    always #5 clk = ~clk;

    bitblade_slice_sequencer #(.ACC_W(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .act(act), .wgt(wgt),
        .prec_i(prec_i), .prec_w(prec_w),
        .signed_i(signed_i), .signed_w(signed_w),
        .last(last),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_sign_i(mul_sign_i), .mul_sign_w(mul_sign_w),
        .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .busy(busy)
    );

    // External multiplier slice: 2b x 2b with optional sign extension.
    logic [5:0] ma6;
    logic [5:0] mb6;
    always_comb begin
        ma6   = mul_sign_i ? {{4{mul_a[1]}}, mul_a} : {4'b0, mul_a};
        mb6   = mul_sign_w ? {{4{mul_b[1]}}, mul_b} : {4'b0, mul_b};
        mul_p = 6'(ma6 * mb6);
    end

    task automatic send(input logic [7:0] a, input logic [7:0] w,
                        input logic [1:0] pi, input logic [1:0] pw,
                        input logic si, input logic sw, input logic lst);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready got %b want 1", in_ready);
        end
        in_valid = 1'b1;
        act = a; wgt = w; prec_i = pi; prec_w = pw;
        signed_i = si; signed_w = sw; last = lst;
        @(negedge clk);
        in_valid = 1'b0;
        act = 8'h5A; wgt = 8'hC3; prec_i = 2'd3; prec_w = 2'd2;
        signed_i = ~si; signed_w = ~sw; last = ~lst;
    endtask

    task automatic run_item(input logic [7:0] a, input logic [7:0] w,
                            input logic [1:0] pi, input logic [1:0] pw,
                            input logic si, input logic sw, input logic lst,
                            output int n);
        send(a, w, pi, pw, si, sw, lst);
        n = 0; hsi = '0; hsw = '0;
        ha0 = mul_a; hb0 = mul_b;
        while (!in_ready && !out_valid && n < 40) begin
            if (n < 16) begin
                hsi[n] = mul_sign_i;
                hsw[n] = mul_sign_w;
            end
            n++;
            @(negedge clk);
        end
        if (n >= 40) begin
            checks++; errors++;
            $display("FAIL run_timeout got %0d cycles", n);
        end
    endtask

    task automatic take_result(input int exp, input string nm);
        checks++;
        if (out_valid !== 1'b1 || out_acc !== AW'(exp)) begin
            errors++;
            $display("FAIL %s_result got v=%b acc=%0d want v=1 acc=%0d",
                     nm, out_valid, $signed(out_acc), exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release got v=%b rdy=%b want v=0 rdy=1",
                     nm, out_valid, in_ready);
        end
    endtask

    task automatic check_idle_outs(input string nm);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
            out_acc !== '0 || mul_a !== 2'b0 || mul_b !== 2'b0 ||
            mul_sign_i !== 1'b0 || mul_sign_w !== 1'b0) begin
            errors++;
            $display("FAIL %s got rdy=%b busy=%b v=%b acc=%0d a=%0d b=%0d si=%b sw=%b want 1 0 0 0 0 0 0 0",
                     nm, in_ready, busy, out_valid, out_acc, mul_a, mul_b,
                     mul_sign_i, mul_sign_w);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        check_idle_outs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outs("post_reset");
    endtask

    task automatic test_unsigned2();
        int n;
        run_item(8'h03, 8'h03, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, n);
        checks++;
        if (n !== 1 || hsi[0] !== 1'b0 || hsw[0] !== 1'b0 ||
            ha0 !== 2'd3 || hb0 !== 2'd3) begin
            errors++;
            $display("FAIL u2_run got n=%0d si=%b sw=%b a=%0d b=%0d want 1 0 0 3 3",
                     n, hsi[0], hsw[0], ha0, hb0);
        end
        take_result(9, "u2");
    endtask

    task automatic test_signed8();
        int n;
        run_item(8'h80, 8'h80, 2'd3, 2'd3, 1'b1, 1'b1, 1'b1, n);
        checks++;
        if (n !== 16 || hsi !== 16'hF000 || hsw !== 16'h8888) begin
            errors++;
            $display("FAIL s8_run got n=%0d si=%h sw=%h want 16 f000 8888",
                     n, hsi, hsw);
        end
        take_result(16384, "s8");
    endtask

    task automatic test_mixed4();
        int n;
        run_item(8'hF8, 8'hAF, 2'd1, 2'd1, 1'b1, 1'b0, 1'b1, n);
        checks++;
        if (n !== 4 || hsi !== 16'h000C || hsw !== 16'h0000) begin
            errors++;
            $display("FAIL m4_run got n=%0d si=%h sw=%h want 4 000c 0000",
                     n, hsi, hsw);
        end
        take_result(-120, "m4");
    endtask

    task automatic test_dot();
        int n;
        run_item(8'h05, 8'hFD, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0, n);
        checks++;
        if (n !== 16 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL dot1 got n=%0d v=%b rdy=%b want 16 0 1",
                     n, out_valid, in_ready);
        end
        run_item(8'h07, 8'h07, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0, n);
        checks++;
        if (n !== 16 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL dot2 got n=%0d v=%b rdy=%b want 16 0 1",
                     n, out_valid, in_ready);
        end
        run_item(8'hFE, 8'h64, 2'd3, 2'd3, 1'b1, 1'b1, 1'b1, n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL dot3_len got %0d want 16", n);
        end
        take_result(-166, "dot");
    endtask

    task automatic test_backpressure();
        int n;
        run_item(8'h0A, 8'h0A, 2'd3, 2'd3, 1'b0, 1'b0, 1'b1, n);
        in_valid = 1'b1;
        act = 8'h77; wgt = 8'h77; prec_i = 2'd0; prec_w = 2'd0; last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_acc !== AW'(100) ||
                in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b acc=%0d rdy=%b busy=%b want 1 100 0 1",
                         k, out_valid, out_acc, in_ready, busy);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        take_result(100, "bp");
        run_item(8'h01, 8'h01, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, n);
        take_result(1, "bp_next");
    endtask

    task automatic test_reset_mid();
        int n;
        send(8'hFF, 8'hFF, 2'd3, 2'd3, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mul_a !== 2'd3 || mul_b !== 2'd3) begin
            errors++;
            $display("FAIL rm_run3 got busy=%b a=%0d b=%0d want 1 3 3",
                     busy, mul_a, mul_b);
        end
        rst = 1'b1;
        #1;
        check_idle_outs("rm_reset");
        @(negedge clk);
        rst = 1'b0;
        run_item(8'h02, 8'h02, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL rm_len got %0d want 1", n);
        end
        take_result(4, "rm");
    endtask

    task automatic test_wrap();
        int n;
        run_item(8'h7F, 8'h7F, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0, n);
        run_item(8'h80, 8'h81, 2'd3, 2'd3, 1'b1, 1'b1, 1'b1, n);
        take_result(16129 + 16256, "sum");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        act = '0; wgt = '0; prec_i = '0; prec_w = '0;
        signed_i = 1'b0; signed_w = 1'b0; last = 1'b0;
        test_reset();
        test_unsigned2();
        test_signed8();
        test_mixed4();
        test_dot();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitblade_slice_sequencer.md
# bitblade_slice_sequencer

Sequencer for one reconfigurable 2-bit x 2-bit multiplier slice with sign-extension control. It accepts one activation/weight pair of 2, 4, 6 or 8 bits per handshake and steps every 2-bit activation slice against every 2-bit weight slice through the external multiplier, one slice pair per cycle. It drives the per-slice sign controls, shift-accumulates the 6-bit partial products, and emits a dot-product result when an item flagged `last` completes. The block sits between the operand feeder and the output buffer of a processing element.

## Interface
- `ACC_W`, default 24: accumulator and result width. Minimum 16.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: operand item valid.
- `in_ready` out 1: item accepted on `in_valid & in_ready`.
- `act` in 8: activation, right-aligned. Bits above the selected precision are ignored.
- `wgt` in 8: weight, right-aligned. Bits above the selected precision are ignored.
- `prec_i` in 2: activation precision code; bits = 2*(`prec_i`+1).
- `prec_w` in 2: weight precision code; bits = 2*(`prec_w`+1).
- `signed_i` in 1: activation is two's complement.
- `signed_w` in 1: weight is two's complement.
- `last` in 1: final item of the current dot product.
- `mul_a` out 2: activation slice sent to the multiplier.
- `mul_b` out 2: weight slice sent to the multiplier.
- `mul_sign_i` out 1: sign-extend `mul_a`.
- `mul_sign_w` out 1: sign-extend `mul_b`.
- `mul_p` in 6: multiplier result for (`mul_a`, `mul_b`), combinational, available in the same cycle.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_acc` out `ACC_W`: signed dot-product result.
- `busy` out 1: high when state != IDLE.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE:** `in_ready`=1. On handshake the block latches `act`, `wgt`, the precisions, the signs and `last`, sets Ni=`prec_i`+1 and Nw=`prec_w`+1, sets slice indices i=0 and j=0, and moves to RUN.
- **RUN:** each cycle the block drives:
  - `mul_a` = act[2i+1:2i]
  - `mul_b` = wgt[2j+1:2j]
  - `mul_sign_i` = `signed_i` & (i==Ni-1)
  - `mul_sign_w` = `signed_w` & (j==Nw-1)
- **RUN accumulation:** acc <= acc + (sign-extend(`mul_p`) << 2*(i+j)).
  - `mul_p` is always treated as 6-bit two's complement. An unsigned 3x3=9 is still positive.
  - The accumulator wraps modulo 2^`ACC_W`; there is no saturation.
- **Slice order:** j is the inner index and i the outer. After the pair (Ni-1, Nw-1):
  - if `last`=1, go to DONE;
  - otherwise go to IDLE with acc retained.
- **DONE:** `out_valid`=1 and `out_acc`=acc, both held stable. On `out_ready`, acc clears to 0 and the state goes to IDLE.
- **Idle outputs:** outside RUN, `mul_a`, `mul_b`, `mul_sign_i` and `mul_sign_w` are all 0.
- **Mixed precision:** precision and sign settings may differ per item inside one dot product; each item uses its own latched settings.
- **Blocked input:** `in_valid` during RUN or DONE is ignored because `in_ready`=0. Input fields may change freely once latched.

## Timing
- **Reset values:**
  - state=IDLE, acc=0
  - `in_ready`=1, `busy`=0, `out_valid`=0, `out_acc`=0
  - all `mul_*` outputs 0
- **Reset mid-operation:** reset takes effect immediately, mid-RUN or mid-DONE, and discards the partial sum and any pending result.
- **Item latency:** an item accepted at cycle t occupies RUN for cycles t+1 .. t+Ni*Nw, i.e. 1 to 16 cycles.
- **Result latency:** for a `last` item, `out_valid` rises at t+Ni*Nw+1.
- **Throughput:** the next item can be accepted at t+Ni*Nw+1 for a non-last item. After a `last` item it can be accepted in the cycle after the `out_ready` handshake.
- **Timing path:** `mul_p` is sampled in the same cycle the slices are driven. The path `mul_*` -> multiplier -> adder -> acc is a single-cycle path.
- **Output backpressure:** `out_valid` stays high and `out_acc` stays constant until `out_ready`. No result is dropped.

## Test plan
- **8-bit signed squared:** 8b signed `act`=-128, `wgt`=-128, `last`=1 -> 16 RUN cycles; `out_valid` at accept+17; `out_acc`=16384.
- **2-bit unsigned:** `act`=3, `wgt`=3, `last`=1 -> 1 RUN cycle with `mul_sign_i`=`mul_sign_w`=0; `out_acc`=9 at accept+2.
- **Mixed 4-bit:** 4b signed `act`=4'h8 (-8) x 4b unsigned `wgt`=15, with garbage in the upper bits of both operands -> 4 RUN cycles; `mul_sign_i`=1 only for i=1; `out_acc`=-120.
- **Dot product:** three 8b signed items 5*-3, 7*7 and -2*100, `last` on the third -> exactly one `out_valid`; `out_acc`=-166; acc reads 0 on the next item.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE -> `out_valid` and `out_acc` stable, `in_ready`=0, offered input ignored. After release, the next 2b item 1*1 gives `out_acc`=1.
- **Reset mid-RUN:** assert `rst` in the 3rd RUN cycle of an 8b x 8b item -> all outputs reset immediately. The following item 2*2 (2b) gives `out_acc`=4.
